// File: rtl/conv_acc_dispatcher.sv
// Queued command dispatcher for the conv/pool engine cluster: FIFO of {mode, w8, tag},
// one job at a time with a one-hot engine select, start pulse, finish wait and watchdog.
module conv_acc_dispatcher #(
  parameter int NUM_ENG = 3,
  parameter int QDEPTH  = 4,
  parameter int W8_W    = 32,
  parameter int TAG_W   = 4,
  parameter int TO_W    = 24
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [NUM_ENG-1:0] cmd_mode,
  input  logic [W8_W-1:0]    cmd_w8,
  input  logic [TAG_W-1:0]   cmd_tag,
  input  logic [TO_W-1:0]    timeout_lim,
  input  logic               abort,
  output logic [NUM_ENG-1:0] eng_start,
  input  logic [NUM_ENG-1:0] eng_finish,
  output logic [NUM_ENG-1:0] sel,
  output logic [W8_W-1:0]    w8,
  output logic               busy,
  output logic               done,
  output logic [TAG_W-1:0]   done_tag,
  output logic               done_err,
  output logic [2:0]         state_dbg
);

  // Handshake: a command is accepted in any cycle where cmd_valid && cmd_ready at the
  // rising edge; cmd_ready never depends on cmd_valid.

  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]         state;
  logic [NUM_ENG-1:0] fifo_mode [QDEPTH];
  logic [W8_W-1:0]    fifo_w8   [QDEPTH];
  logic [TAG_W-1:0]   fifo_tag  [QDEPTH];
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;

  logic [NUM_ENG-1:0] mode_r;
  logic [W8_W-1:0]    w8_r;
  logic [TAG_W-1:0]   tag_r;
  logic               err_r;
  logic [TO_W-1:0]    wd_cnt;

  logic [NUM_ENG-1:0] head_mode;
  logic               head_onehot;
  logic               fin_hit;
  logic               timeout_hit;

  // Wrap bit distinguishes full from empty when the index bits match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd_ready  = !fifo_full && !abort;
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state == S_LOAD) && !abort;

  assign head_mode   = fifo_mode[rd_ptr[AW-1:0]];
  assign head_onehot = (head_mode != '0) && ((head_mode & (head_mode - NUM_ENG'(1))) == '0);
  assign fin_hit     = |(eng_finish & mode_r);
  assign timeout_hit = (timeout_lim != '0) && (wd_cnt == timeout_lim - TO_W'(1));

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mode[wr_ptr[AW-1:0]] <= cmd_mode;
      fifo_w8[wr_ptr[AW-1:0]]   <= cmd_w8;
      fifo_tag[wr_ptr[AW-1:0]]  <= cmd_tag;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= S_IDLE;
      mode_r <= '0;
      w8_r   <= '0;
      tag_r  <= '0;
      err_r  <= 1'b0;
      wd_cnt <= '0;
    end else if (abort) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty) state <= S_LOAD;
        end
        S_LOAD: begin
          mode_r <= head_mode;
          w8_r   <= fifo_w8[rd_ptr[AW-1:0]];
          tag_r  <= fifo_tag[rd_ptr[AW-1:0]];
          if (head_onehot) begin
            err_r <= 1'b0;
            state <= S_START;
          end else begin
            err_r <= 1'b1;
            state <= S_DONE;
          end
        end
        S_START: begin
          wd_cnt <= '0;
          state  <= S_RUN;
        end
        S_RUN: begin
          // Finish has priority over a watchdog expiry in the same cycle.
          if (fin_hit) begin
            err_r <= 1'b0;
            state <= S_DONE;
          end else if (timeout_hit) begin
            err_r <= 1'b1;
            state <= S_DONE;
          end else if (wd_cnt != {TO_W{1'b1}}) begin
            wd_cnt <= wd_cnt + TO_W'(1);
          end
        end
        S_DONE: begin
          state <= fifo_empty ? S_IDLE : S_LOAD;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic in_job;
  assign in_job = (state == S_START) || (state == S_RUN) || (state == S_DONE);

  assign sel       = in_job ? mode_r : '0;
  assign eng_start = (state == S_START) ? mode_r : '0;
  assign w8        = w8_r;
  assign done      = (state == S_DONE);
  assign done_tag  = done ? tag_r : '0;
  assign done_err  = done && err_r;
  assign busy      = (state != S_IDLE) || !fifo_empty;
  assign state_dbg = state;

endmodule

// File: tb/tb_conv_acc_dispatcher.sv
// Directed bench for conv_acc_dispatcher: job-age model checked every cycle plus
// hand-computed cycle-exact expectations for each scenario.
module tb_conv_acc_dispatcher;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_mode = '0;
  logic [31:0] cmd_w8 = '0;
  logic [3:0]  cmd_tag = '0;
  logic [23:0] timeout_lim = '0;
  logic        abort = 1'b0;
  logic [2:0]  eng_start;
  logic [2:0]  eng_finish = '0;
  logic [2:0]  sel;
  logic [31:0] w8;
  logic        busy;
  logic        done;
  logic [3:0]  done_tag;
  logic        done_err;
  logic [2:0]  state_dbg;

  conv_acc_dispatcher #(.NUM_ENG(3), .QDEPTH(4), .W8_W(32), .TAG_W(4), .TO_W(24)) dut (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_w8(cmd_w8), .cmd_tag(cmd_tag), .timeout_lim(timeout_lim),
    .abort(abort), .eng_start(eng_start), .eng_finish(eng_finish), .sel(sel), .w8(w8),
    .busy(busy), .done(done), .done_tag(done_tag), .done_err(done_err), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL global_timeout: bench did not reach its end, cycle %0d", cyc);
    $fatal(1);
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge, checks at the falling edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    step();
    cmd_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic tick_fin(input logic [2:0] f);
    step();
    cmd_valid = 1'b0;
    eng_finish = f;
    @(negedge clk);
  endtask

  task automatic offer(input logic [2:0] m, input logic [31:0] d, input logic [3:0] t);
    step();
    cmd_valid = 1'b1;
    cmd_mode = m;
    cmd_w8 = d;
    cmd_tag = t;
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_eng_start"}, 32'(eng_start), 32'd0);
    chk({tag, "_sel"}, 32'(sel), 32'd0);
    chk({tag, "_w8"}, w8, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_done_tag"}, 32'(done_tag), 32'd0);
    chk({tag, "_done_err"}, 32'(done_err), 32'd0);
  endtask

  // scoreboard model: queue of pending commands and the age of the current job
  typedef struct packed {
    logic [2:0]  mode;
    logic [31:0] w8;
    logic [3:0]  tag;
  } cmd_t;

  cmd_t        mq[$];
  cmd_t        cur;
  bit          have_job = 0;
  int          age = 0;
  int          done_age = -1;
  bit          exp_err = 0;
  int          run_cnt = 0;
  logic [31:0] last_w8 = '0;

  always @(negedge clk) begin : model
    logic [2:0] e_sel, e_start;
    logic       e_done, e_ready, e_busy;
    bit         pushing;
    if (!rstn) begin
      mq.delete();
      have_job = 0;
      last_w8 = '0;
    end else begin
      e_ready = (mq.size() < 4) && !abort;
      e_busy  = have_job || (mq.size() != 0);
      e_sel = '0;
      e_start = '0;
      e_done = 1'b0;
      if (have_job && age >= 1) begin
        e_sel = cur.mode;
        if (age == 1 && done_age != 1) e_start = cur.mode;
        if (age == done_age) e_done = 1'b1;
      end
      chk("m_cmd_ready", 32'(cmd_ready), 32'(e_ready));
      chk("m_busy", 32'(busy), 32'(e_busy));
      chk("m_sel", 32'(sel), 32'(e_sel));
      chk("m_eng_start", 32'(eng_start), 32'(e_start));
      chk("m_done", 32'(done), 32'(e_done));
      chk("m_w8", w8, last_w8);
      if (e_done) begin
        chk("m_done_tag", 32'(done_tag), 32'(cur.tag));
        chk("m_done_err", 32'(done_err), 32'(exp_err));
      end
      if (abort) begin
        mq.delete();
        have_job = 0;
      end else begin
        pushing = cmd_valid && e_ready;
        if (!have_job) begin
          if (mq.size() != 0) begin
            have_job = 1;
            age = 0;
            done_age = -1;
          end
        end else if (age == 0) begin
          cur = mq.pop_front();
          last_w8 = cur.w8;
          age = 1;
          run_cnt = 0;
          exp_err = 0;
          if ($countones(cur.mode) != 1) begin
            done_age = 1;
            exp_err = 1;
          end
        end else if (age == done_age) begin
          if (mq.size() != 0) begin
            age = 0;
            done_age = -1;
          end else begin
            have_job = 0;
          end
        end else if (age == 1) begin
          age = 2;
        end else begin
          if (done_age < 0) begin
            if ((eng_finish & cur.mode) != 0) begin
              done_age = age + 1;
              exp_err = 0;
            end else if (timeout_lim != 0 && run_cnt == int'(timeout_lim) - 1) begin
              done_age = age + 1;
              exp_err = 1;
            end else if (run_cnt < 24'hFFFFFF) begin
              run_cnt++;
            end
          end
          age++;
        end
        if (pushing) mq.push_back('{mode: cmd_mode, w8: cmd_w8, tag: cmd_tag});
      end
    end
  end

  logic [2:0] mode_tab [1:5] = '{3'b001, 3'b100, 3'b010, 3'b001, 3'b100};
  int done_cyc;
  int n_done;

  initial begin
    // reset
    @(negedge clk);
    chk_reset_outputs("rst");
    step();
    rstn = 1'b1;
    @(negedge clk);

    // single job, cycle 0 = accept
    offer(3'b010, 32'h1234_5678, 4'd5);
    chk("s1_ready", 32'(cmd_ready), 32'd1);
    tick(); tick(); tick();
    chk("s1_start", 32'(eng_start), 32'h2);
    chk("s1_sel", 32'(sel), 32'h2);
    chk("s1_w8", w8, 32'h1234_5678);
    repeat (6) tick();
    tick_fin(3'b010);
    tick_fin(3'b000);
    chk("s1_done", 32'(done), 32'd1);
    chk("s1_tag", 32'(done_tag), 32'd5);
    chk("s1_err", 32'(done_err), 32'd0);
    chk("s1_sel_done", 32'(sel), 32'h2);
    tick();
    chk("s1_sel_after", 32'(sel), 32'h0);
    tick(); tick();

    // fill the FIFO behind a stalled job, then drain back-to-back
    offer(mode_tab[1], 32'hA1, 4'd1);
    tick(); tick(); tick();
    chk("f_start1", 32'(eng_start), 32'(mode_tab[1]));
    tick();
    for (int k = 2; k <= 5; k++) begin
      offer(mode_tab[k], 32'hA0 + 32'(k), 4'(k));
      chk("f_ready_open", 32'(cmd_ready), 32'd1);
    end
    offer(3'b010, 32'hFF, 4'd6);
    chk("f_ready_full", 32'(cmd_ready), 32'd0);
    tick();
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) begin
        for (int i = 0; i < 20 && eng_start == 3'b000; i++) tick();
        chk("f_start", 32'(eng_start), 32'(mode_tab[k]));
        chk("f_gap", 32'(cyc - done_cyc), 32'd2);
        if (k == 2) chk("f_ready_freed", 32'(cmd_ready), 32'd1);
      end
      tick(); tick();
      tick_fin(mode_tab[k]);
      tick_fin(3'b000);
      chk("f_done", 32'(done), 32'd1);
      chk("f_tag", 32'(done_tag), 32'(k));
      done_cyc = cyc;
      if (k == 1) begin
        tick();
        chk("f_ready_popcycle", 32'(cmd_ready), 32'd0);
      end
    end
    tick(); tick();
    chk("f_idle", 32'(busy), 32'd0);

    // illegal mode
    offer(3'b011, 32'hDEAD, 4'd9);
    chk("i_start0", 32'(eng_start), 32'd0);
    tick();
    chk("i_start1", 32'(eng_start), 32'd0);
    tick();
    chk("i_start2", 32'(eng_start), 32'd0);
    tick();
    chk("i_done", 32'(done), 32'd1);
    chk("i_err", 32'(done_err), 32'd1);
    chk("i_tag", 32'(done_tag), 32'd9);
    chk("i_start3", 32'(eng_start), 32'd0);
    tick(); tick();

    // watchdog with limit 8: START at 3, done at 12
    timeout_lim = 24'd8;
    offer(3'b100, 32'h55, 4'd3);
    tick(); tick(); tick();
    chk("w_start", 32'(eng_start), 32'h4);
    repeat (8) tick();
    chk("w_not_yet", 32'(done), 32'd0);
    tick();
    chk("w_done", 32'(done), 32'd1);
    chk("w_err", 32'(done_err), 32'd1);
    chk("w_tag", 32'(done_tag), 32'd3);
    tick(); tick();

    // watchdog disabled
    timeout_lim = 24'd0;
    offer(3'b001, 32'h66, 4'd4);
    tick(); tick(); tick();
    n_done = 0;
    repeat (1000) begin
      tick();
      if (done) n_done++;
    end
    chk("w0_no_done", 32'(n_done), 32'd0);
    chk("w0_busy", 32'(busy), 32'd1);

    // abort with two commands queued behind the running job
    offer(3'b010, 32'h77, 4'd10);
    offer(3'b100, 32'h88, 4'd11);
    tick();
    step();
    abort = 1'b1;
    cmd_valid = 1'b1;
    cmd_mode = 3'b001;
    cmd_w8 = 32'hEE;
    cmd_tag = 4'd13;
    @(negedge clk);
    chk("a_ready", 32'(cmd_ready), 32'd0);
    step();
    abort = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("a_sel", 32'(sel), 32'd0);
    chk("a_busy", 32'(busy), 32'd0);
    chk("a_done", 32'(done), 32'd0);
    tick(); tick();
    offer(3'b010, 32'h99, 4'd12);
    tick(); tick(); tick();
    chk("a_start", 32'(eng_start), 32'h2);
    chk("a_w8", w8, 32'h99);
    tick();
    tick_fin(3'b010);
    tick_fin(3'b000);
    chk("a_done_new", 32'(done), 32'd1);
    chk("a_tag_new", 32'(done_tag), 32'd12);
    tick(); tick();

    // stale finish held through the next START, foreign finish during RUN
    offer(3'b100, 32'h0A, 4'd6);
    offer(3'b100, 32'h0B, 4'd7);
    tick(); tick(); tick();
    tick_fin(3'b100);
    tick();
    chk("st_done_a", 32'(done), 32'd1);
    chk("st_tag_a", 32'(done_tag), 32'd6);
    tick(); tick();
    chk("st_start_b", 32'(eng_start), 32'h4);
    tick_fin(3'b001);
    chk("st_no_stale", 32'(done), 32'd0);
    n_done = 0;
    repeat (4) begin
      tick();
      if (done) n_done++;
    end
    tick_fin(3'b101);
    if (done) n_done++;
    chk("st_no_foreign", 32'(n_done), 32'd0);
    tick_fin(3'b000);
    chk("st_done_b", 32'(done), 32'd1);
    chk("st_tag_b", 32'(done_tag), 32'd7);
    chk("st_err_b", 32'(done_err), 32'd0);
    tick(); tick();

    // asynchronous reset mid-RUN
    offer(3'b001, 32'hCC, 4'd8);
    repeat (4) tick();
    chk("r_sel_run", 32'(sel), 32'h1);
    step();
    rstn = 1'b0;
    #1;
    chk_reset_outputs("r_async");
    @(negedge clk);
    step();
    rstn = 1'b1;
    @(negedge clk);
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
